// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains the character FIFO one byte at a time.
// Bit timing comes from a CDIV-cycle divider; frames_sent counts completed frames.
module fifo_uart_tx #(
  parameter int CDIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  input  logic [7:0]  fifo_q,
  output logic        txd,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frames_sent
);

  localparam int CW = (CDIV > 1) ? $clog2(CDIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CDIV - 1);
  localparam logic [CW-1:0] DIV_PRE  = CW'((CDIV > 1) ? CDIV - 2 : 0);
  localparam logic ONE_CYCLE_BIT = (CDIV == 1);

  typedef enum logic [2:0] {IDLE, READ, LOAD, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      shift;
  logic [CW-1:0]   div;
  logic [2:0]      bitidx;
  logic            bit_end;

  always_comb begin
    bit_end = (div == DIV_LAST);
  end

  // Outputs are registered alongside the state, so each branch loads the value
  // the output must carry while the next state is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift       <= '0;
      div         <= '0;
      bitidx      <= '0;
      txd         <= 1'b1;
      fifo_rd     <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      frames_sent <= '0;
    end else begin
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!fifo_empty) begin
            state   <= READ;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        READ: begin
          state <= LOAD;
        end
        LOAD: begin
          shift  <= fifo_q;
          div    <= '0;
          bitidx <= '0;
          txd    <= 1'b0;
          state  <= START;
        end
        START: begin
          if (bit_end) begin
            div   <= '0;
            txd   <= shift[0];
            state <= DATA;
          end else begin
            div <= div + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            div <= '0;
            if (bitidx == 3'd7) begin
              txd     <= 1'b1;
              tx_done <= ONE_CYCLE_BIT;
              state   <= STOP;
            end else begin
              shift  <= {1'b0, shift[7:1]};
              bitidx <= bitidx + 3'd1;
              txd    <= shift[1];
            end
          end else begin
            div <= div + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            div         <= '0;
            busy        <= 1'b0;
            frames_sent <= frames_sent + 16'd1;
            state       <= IDLE;
          end else begin
            div     <= div + CW'(1);
            tx_done <= (div == DIV_PRE);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
